// File: rtl/exu_lsu_ctrl_pkg.sv
// Shared types and helpers for the EXU load/store control slice:
// bus widths, access-size encodings, in-flight entry layout, load data formatting.
package exu_lsu_ctrl_pkg;

   localparam int XLEN      = 32;
   localparam int ADDR_SIZE = 32;
   localparam int LSU_OTF_W = 6;

   typedef enum logic [1:0] {
      LSU_SIZE_B   = 2'b00,
      LSU_SIZE_H   = 2'b01,
      LSU_SIZE_W   = 2'b10,
      LSU_SIZE_RSV = 2'b11
   } lsu_size_e;

   // Field order fixes the 6-bit layout {read, size, usign, ofst}
   typedef struct packed {
      logic      read;
      lsu_size_e size;
      logic      usign;
      logic [1:0] ofst;
   } lsu_otf_ent_t;

   function automatic logic [XLEN-1:0] lsu_fmt_load(input logic [XLEN-1:0] rdata,
                                                     input lsu_otf_ent_t ent);
      logic [XLEN-1:0] shifted;
      logic [XLEN-1:0] fmt;
      shifted = rdata >> {ent.ofst, 3'b000};
      case (ent.size)
         LSU_SIZE_B: fmt = ent.usign ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
         LSU_SIZE_H: fmt = ent.usign ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
         default:    fmt = rdata;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/exu_lsu_ctrl_if.sv
// Handshake bundle around the LSU controller: AGU command/response side,
// memory-side ICB bus and the write-back beat.
interface exu_lsu_ctrl_if
   import exu_lsu_ctrl_pkg::*;
();

   logic                   agu_icb_cmd_valid;
   logic                   agu_icb_cmd_ready;
   logic [ADDR_SIZE-1:0]   agu_icb_cmd_addr;
   logic                   agu_icb_cmd_read;
   logic [XLEN-1:0]        agu_icb_cmd_wdata;
   logic [XLEN/8-1:0]      agu_icb_cmd_wmask;
   logic [1:0]             agu_icb_cmd_size;
   logic                   agu_icb_cmd_usign;
   logic [XLEN-1:0]        agu_icb_rsp_rdata;

   logic                   lsu_icb_cmd_valid;
   logic                   lsu_icb_cmd_ready;
   logic [ADDR_SIZE-1:0]   lsu_icb_cmd_addr;
   logic                   lsu_icb_cmd_read;
   logic [XLEN-1:0]        lsu_icb_cmd_wdata;
   logic [XLEN/8-1:0]      lsu_icb_cmd_wmask;
   logic                   lsu_icb_rsp_valid;
   logic                   lsu_icb_rsp_ready;
   logic [XLEN-1:0]        lsu_icb_rsp_rdata;
   logic                   lsu_icb_rsp_err;

   logic                   lsu_o_valid;
   logic                   lsu_o_ready;
   logic [XLEN-1:0]        lsu_o_wbck_wdat;
   logic                   lsu_o_cmt_ld;
   logic                   lsu_o_cmt_err;
   logic                   lsu_active;

   // Controller side
   modport slave (
      input  agu_icb_cmd_valid, agu_icb_cmd_addr, agu_icb_cmd_read, agu_icb_cmd_wdata,
             agu_icb_cmd_wmask, agu_icb_cmd_size, agu_icb_cmd_usign,
             lsu_icb_cmd_ready, lsu_icb_rsp_valid, lsu_icb_rsp_rdata, lsu_icb_rsp_err,
             lsu_o_ready,
      output agu_icb_cmd_ready, agu_icb_rsp_rdata,
             lsu_icb_cmd_valid, lsu_icb_cmd_addr, lsu_icb_cmd_read, lsu_icb_cmd_wdata,
             lsu_icb_cmd_wmask, lsu_icb_rsp_ready,
             lsu_o_valid, lsu_o_wbck_wdat, lsu_o_cmt_ld, lsu_o_cmt_err, lsu_active
   );

   // Environment side (AGU, memory bus and write-back stage together)
   modport master (
      output agu_icb_cmd_valid, agu_icb_cmd_addr, agu_icb_cmd_read, agu_icb_cmd_wdata,
             agu_icb_cmd_wmask, agu_icb_cmd_size, agu_icb_cmd_usign,
             lsu_icb_cmd_ready, lsu_icb_rsp_valid, lsu_icb_rsp_rdata, lsu_icb_rsp_err,
             lsu_o_ready,
      input  agu_icb_cmd_ready, agu_icb_rsp_rdata,
             lsu_icb_cmd_valid, lsu_icb_cmd_addr, lsu_icb_cmd_read, lsu_icb_cmd_wdata,
             lsu_icb_cmd_wmask, lsu_icb_rsp_ready,
             lsu_o_valid, lsu_o_wbck_wdat, lsu_o_cmt_ld, lsu_o_cmt_err, lsu_active
   );

endinterface

// File: rtl/exu_lsu_otf_fifo.sv
// Small synchronous FIFO with a fall-through head; full/empty derive from a
// registered occupancy count, so a same-cycle pop never frees a full slot early.
module exu_lsu_otf_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 6,
   parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int               CNT_W    = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] cnt_r;
   logic             push_s;
   logic             pop_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] n;
      if (p == PTR_LAST) begin
         n = '0;
      end else begin
         n = p + PTR_W'(1);
      end
      return n;
   endfunction

   assign full   = (cnt_r == CNT_FULL);
   assign empty  = (cnt_r == CNT_W'(0));
   assign push_s = push & ~full;
   assign pop_s  = pop & ~empty;
   assign dout   = mem_r[rd_ptr_r];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
         if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CNT_W'(1);
            2'b01:   cnt_r <= cnt_r - CNT_W'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // Entry storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

endmodule

// File: rtl/exu_lsu_ctrl.sv
// LSU control: forwards AGU load/store commands to the memory bus, tracks
// outstanding accesses and formats in-order responses into write-back beats.
module exu_lsu_ctrl
   import exu_lsu_ctrl_pkg::*;
#(
   parameter int OTF_DEPTH = 2,
   parameter int OTF_PTR_W = (OTF_DEPTH > 1) ? $clog2(OTF_DEPTH) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   exu_lsu_ctrl_if.slave  bus
);

   logic         full_s;
   logic         empty_s;
   logic         cmd_valid_s;
   logic         cmd_hsk_s;
   logic         rsp_ready_s;
   logic         rsp_hsk_s;
   logic         o_valid_s;
   lsu_otf_ent_t push_ent_s;
   lsu_otf_ent_t head_s;
   logic [XLEN-1:0] wbck_s;

   assign cmd_valid_s = bus.agu_icb_cmd_valid & ~full_s;
   assign cmd_hsk_s   = cmd_valid_s & bus.lsu_icb_cmd_ready;

   assign bus.lsu_icb_cmd_valid = cmd_valid_s;
   assign bus.agu_icb_cmd_ready = bus.lsu_icb_cmd_ready & ~full_s;
   assign bus.lsu_icb_cmd_addr  = bus.agu_icb_cmd_addr;
   assign bus.lsu_icb_cmd_read  = bus.agu_icb_cmd_read;
   assign bus.lsu_icb_cmd_wdata = bus.agu_icb_cmd_wdata;
   assign bus.lsu_icb_cmd_wmask = bus.agu_icb_cmd_wmask;

   assign push_ent_s.read  = bus.agu_icb_cmd_read;
   assign push_ent_s.size  = lsu_size_e'(bus.agu_icb_cmd_size);
   assign push_ent_s.usign = bus.agu_icb_cmd_usign;
   assign push_ent_s.ofst  = bus.agu_icb_cmd_addr[1:0];

   // A response with nothing outstanding is neither accepted nor forwarded
   assign o_valid_s   = bus.lsu_icb_rsp_valid & ~empty_s;
   assign rsp_ready_s = bus.lsu_o_ready & ~empty_s;
   assign rsp_hsk_s   = bus.lsu_icb_rsp_valid & rsp_ready_s;

   exu_lsu_otf_fifo #(
      .DEPTH (OTF_DEPTH),
      .WIDTH (LSU_OTF_W),
      .PTR_W (OTF_PTR_W)
   ) u_otf_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_hsk_s),
      .pop   (rsp_hsk_s),
      .din   (push_ent_s),
      .dout  (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Load result selection; stores write back zero
   always_comb begin
      wbck_s = '0;
      if (head_s.read) begin
         wbck_s = lsu_fmt_load(bus.lsu_icb_rsp_rdata, head_s);
      end else begin
         wbck_s = '0;
      end
   end

   assign bus.lsu_icb_rsp_ready = rsp_ready_s;
   assign bus.lsu_o_valid       = o_valid_s;
   assign bus.lsu_o_wbck_wdat   = wbck_s;
   assign bus.agu_icb_rsp_rdata = wbck_s;
   assign bus.lsu_o_cmt_ld      = head_s.read;
   assign bus.lsu_o_cmt_err     = bus.lsu_icb_rsp_err & o_valid_s;
   assign bus.lsu_active        = ~empty_s;

endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// Directed bench for exu_lsu_ctrl: load formatting, store pass-through,
// in-flight limit, back-pressure, error flag, stray response and reset flush.
module tb_exu_lsu_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   exu_lsu_ctrl_if bus_if ();

   exu_lsu_ctrl #(.OTF_DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic cmd_drive(input logic vld, input logic read, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wmask,
                            input logic [1:0] size, input logic usign);
      bus_if.agu_icb_cmd_valid = vld;
      bus_if.agu_icb_cmd_read  = read;
      bus_if.agu_icb_cmd_addr  = addr;
      bus_if.agu_icb_cmd_wdata = wdata;
      bus_if.agu_icb_cmd_wmask = wmask;
      bus_if.agu_icb_cmd_size  = size;
      bus_if.agu_icb_cmd_usign = usign;
   endtask

   task automatic rsp_drive(input logic vld, input logic [31:0] rdata, input logic err,
                            input logic ordy);
      bus_if.lsu_icb_rsp_valid = vld;
      bus_if.lsu_icb_rsp_rdata = rdata;
      bus_if.lsu_icb_rsp_err   = err;
      bus_if.lsu_o_ready       = ordy;
   endtask

   // One command followed by its response in the next cycle
   task automatic single_txn(input string tag, input logic read, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wmask,
                             input logic [1:0] size, input logic usign,
                             input logic [31:0] rdata, input logic [31:0] exp);
      @(negedge clk);
      cmd_drive(1'b1, read, addr, wdata, wmask, size, usign);
      #1;
      check_eq({tag, "_cmd_valid"}, {31'd0, bus_if.lsu_icb_cmd_valid}, 32'd1);
      check_eq({tag, "_cmd_addr"}, bus_if.lsu_icb_cmd_addr, addr);
      check_eq({tag, "_cmd_read"}, {31'd0, bus_if.lsu_icb_cmd_read}, {31'd0, read});
      check_eq({tag, "_cmd_wdata"}, bus_if.lsu_icb_cmd_wdata, wdata);
      check_eq({tag, "_cmd_wmask"}, {28'd0, bus_if.lsu_icb_cmd_wmask}, {28'd0, wmask});
      @(negedge clk);
      cmd_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 2'd0, 1'b0);
      rsp_drive(1'b1, rdata, 1'b0, 1'b1);
      #1;
      check_eq({tag, "_active"}, {31'd0, bus_if.lsu_active}, 32'd1);
      check_eq({tag, "_o_valid"}, {31'd0, bus_if.lsu_o_valid}, 32'd1);
      check_eq({tag, "_wdat"}, bus_if.lsu_o_wbck_wdat, exp);
      check_eq({tag, "_agu_rdata"}, bus_if.agu_icb_rsp_rdata, exp);
      check_eq({tag, "_cmt_ld"}, {31'd0, bus_if.lsu_o_cmt_ld}, {31'd0, read});
      check_eq({tag, "_cmt_err"}, {31'd0, bus_if.lsu_o_cmt_err}, 32'd0);
      @(negedge clk);
      rsp_drive(1'b0, 32'd0, 1'b0, 1'b1);
      #1;
      check_eq({tag, "_idle"}, {31'd0, bus_if.lsu_active}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 2'd0, 1'b0);
      bus_if.lsu_icb_cmd_ready = 1'b1;
      rsp_drive(1'b0, 32'd0, 1'b0, 1'b1);
      #1;
      check_eq("rst_active", {31'd0, bus_if.lsu_active}, 32'd0);
      check_eq("rst_o_valid", {31'd0, bus_if.lsu_o_valid}, 32'd0);
      check_eq("rst_rsp_ready", {31'd0, bus_if.lsu_icb_rsp_ready}, 32'd0);
      check_eq("rst_cmd_ready", {31'd0, bus_if.agu_icb_cmd_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      single_txn("lb_s",  1'b1, 32'h0000_1003, 32'd0, 4'h0, 2'b00, 1'b0, 32'h80FF_FFFF, 32'hFFFF_FF80);
      single_txn("lb_u",  1'b1, 32'h0000_1003, 32'd0, 4'h0, 2'b00, 1'b1, 32'h80FF_FFFF, 32'h0000_0080);
      single_txn("lh_p",  1'b1, 32'h0000_2002, 32'd0, 4'h0, 2'b01, 1'b0, 32'h7FFF_1234, 32'h0000_7FFF);
      single_txn("lh_n",  1'b1, 32'h0000_2002, 32'd0, 4'h0, 2'b01, 1'b0, 32'h8001_ABCD, 32'hFFFF_8001);
      single_txn("sw",    1'b0, 32'h0000_3000, 32'hDEAD_BEEF, 4'hF, 2'b10, 1'b0, 32'h1234_5678, 32'h0000_0000);
      single_txn("lw_r3", 1'b1, 32'h0000_4000, 32'd0, 4'h0, 2'b11, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);

      // Fill: A = LB signed @0x100, B = LHU @0x102, C = LW @0x108
      @(negedge clk);
      cmd_drive(1'b1, 1'b1, 32'h0000_0100, 32'd0, 4'h0, 2'b00, 1'b0);
      @(negedge clk);
      cmd_drive(1'b1, 1'b1, 32'h0000_0102, 32'd0, 4'h0, 2'b01, 1'b1);
      @(negedge clk);
      cmd_drive(1'b1, 1'b1, 32'h0000_0108, 32'd0, 4'h0, 2'b10, 1'b0);
      #1;
      check_eq("full_cmd_ready", {31'd0, bus_if.agu_icb_cmd_ready}, 32'd0);
      check_eq("full_cmd_valid", {31'd0, bus_if.lsu_icb_cmd_valid}, 32'd0);
      check_eq("full_active", {31'd0, bus_if.lsu_active}, 32'd1);
      @(negedge clk);
      rsp_drive(1'b1, 32'h8081_8283, 1'b0, 1'b1);
      #1;
      check_eq("pop_a_cmd_ready", {31'd0, bus_if.agu_icb_cmd_ready}, 32'd0);
      check_eq("pop_a_wdat", bus_if.lsu_o_wbck_wdat, 32'hFFFF_FF83);
      @(negedge clk);
      rsp_drive(1'b0, 32'd0, 1'b0, 1'b1);
      #1;
      check_eq("after_pop_cmd_ready", {31'd0, bus_if.agu_icb_cmd_ready}, 32'd1);
      @(negedge clk);
      cmd_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 2'd0, 1'b0);
      rsp_drive(1'b1, 32'h8081_8283, 1'b0, 1'b0);
      #1;
      check_eq("hold_rsp_ready", {31'd0, bus_if.lsu_icb_rsp_ready}, 32'd0);
      check_eq("hold_o_valid", {31'd0, bus_if.lsu_o_valid}, 32'd1);
      check_eq("hold_wdat_b", bus_if.lsu_o_wbck_wdat, 32'h0000_8081);
      @(negedge clk);
      #1;
      check_eq("hold2_wdat_b", bus_if.lsu_o_wbck_wdat, 32'h0000_8081);
      check_eq("hold2_cmd_ready", {31'd0, bus_if.agu_icb_cmd_ready}, 32'd0);
      @(negedge clk);
      rsp_drive(1'b1, 32'h8081_8283, 1'b0, 1'b1);
      #1;
      check_eq("rel_rsp_ready", {31'd0, bus_if.lsu_icb_rsp_ready}, 32'd1);
      check_eq("rel_cmt_err", {31'd0, bus_if.lsu_o_cmt_err}, 32'd0);
      @(negedge clk);
      rsp_drive(1'b1, 32'h8081_8283, 1'b1, 1'b1);
      #1;
      check_eq("err_wdat_c", bus_if.lsu_o_wbck_wdat, 32'h8081_8283);
      check_eq("err_cmt_err", {31'd0, bus_if.lsu_o_cmt_err}, 32'd1);
      check_eq("err_active", {31'd0, bus_if.lsu_active}, 32'd1);
      @(negedge clk);
      #1;
      check_eq("stray_rsp_ready", {31'd0, bus_if.lsu_icb_rsp_ready}, 32'd0);
      check_eq("stray_o_valid", {31'd0, bus_if.lsu_o_valid}, 32'd0);
      check_eq("stray_cmt_err", {31'd0, bus_if.lsu_o_cmt_err}, 32'd0);
      check_eq("stray_active", {31'd0, bus_if.lsu_active}, 32'd0);

      // Reset with two loads outstanding
      @(negedge clk);
      rsp_drive(1'b0, 32'd0, 1'b0, 1'b1);
      cmd_drive(1'b1, 1'b1, 32'h0000_0200, 32'd0, 4'h0, 2'b10, 1'b0);
      @(negedge clk);
      cmd_drive(1'b1, 1'b1, 32'h0000_0204, 32'd0, 4'h0, 2'b10, 1'b0);
      @(negedge clk);
      cmd_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 2'd0, 1'b0);
      #1;
      check_eq("pre_rst_active", {31'd0, bus_if.lsu_active}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_active", {31'd0, bus_if.lsu_active}, 32'd0);
      check_eq("mid_rst_cmd_ready", {31'd0, bus_if.agu_icb_cmd_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_drive(1'b1, 32'h5555_AAAA, 1'b0, 1'b1);
      #1;
      check_eq("post_rst_o_valid", {31'd0, bus_if.lsu_o_valid}, 32'd0);
      check_eq("post_rst_rsp_ready", {31'd0, bus_if.lsu_icb_rsp_ready}, 32'd0);
      @(negedge clk);
      rsp_drive(1'b0, 32'd0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/exu_lsu_ctrl.md
Name: exu_lsu_ctrl

Overview:
- Downstream consumer of the AGU's ICB command channel; forwards each load/store command to the memory-side ICB bus.
- Tracks outstanding transactions in a small in-flight FIFO.
- Aligns and sign/zero-extends load response data, then presents a write-back/commit beat to the LSU write-back stage.
- Sits between the EXU AGU and the memory/bus interface.

Parameters:
- OTF_DEPTH, 2, number of outstanding (issued, not yet responded) transactions; power of two, minimum 1.
- OTF_PTR_W, $clog2(OTF_DEPTH) (1 when OTF_DEPTH is 1), FIFO pointer width.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- agu_icb_cmd_valid  input  1  command from AGU valid
- agu_icb_cmd_ready  output  1  command accepted
- agu_icb_cmd_addr  input  `ADDR_SIZE  byte address
- agu_icb_cmd_read  input  1  1=load, 0=store
- agu_icb_cmd_wdata  input  `XLEN  lane-replicated store data
- agu_icb_cmd_wmask  input  `XLEN/8  store byte mask
- agu_icb_cmd_size  input  2  00=byte, 01=half, 10=word
- agu_icb_cmd_usign  input  1  unsigned load
- agu_icb_rsp_rdata  output  `XLEN  aligned, extended load data returned to AGU
- lsu_icb_cmd_valid  output  1  bus command valid
- lsu_icb_cmd_ready  input  1  bus command ready
- lsu_icb_cmd_addr  output  `ADDR_SIZE  bus address
- lsu_icb_cmd_read  output  1  bus read
- lsu_icb_cmd_wdata  output  `XLEN  bus write data
- lsu_icb_cmd_wmask  output  `XLEN/8  bus write mask
- lsu_icb_rsp_valid  input  1  bus response valid
- lsu_icb_rsp_ready  output  1  bus response accepted
- lsu_icb_rsp_rdata  input  `XLEN  raw bus read data
- lsu_icb_rsp_err  input  1  bus error
- lsu_o_valid  output  1  write-back beat valid
- lsu_o_ready  input  1  write-back stage ready
- lsu_o_wbck_wdat  output  `XLEN  load result; 0 for stores
- lsu_o_cmt_ld  output  1  beat is a load
- lsu_o_cmt_err  output  1  bus error on this beat
- lsu_active  output  1  at least one transaction outstanding

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous, active-low.
- Reset: FIFO read/write pointers and count cleared to 0. All outputs are combinational from state and inputs.
  - With FIFO empty: lsu_o_valid=0, lsu_icb_rsp_ready=0, lsu_active=0.
  - agu_icb_cmd_ready equals lsu_icb_cmd_ready.
- Command path, zero latency, no registering:
  - lsu_icb_cmd_valid = agu_icb_cmd_valid & ~full.
  - agu_icb_cmd_ready = lsu_icb_cmd_ready & ~full.
  - addr, read, wdata and wmask pass straight through.
- Push: on cmd handshake (lsu_icb_cmd_valid & lsu_icb_cmd_ready), push entry {read, size, usign, addr[1:0]} (6 bits).
- Response path:
  - lsu_o_valid = lsu_icb_rsp_valid & ~empty.
  - lsu_icb_rsp_ready = lsu_o_ready & ~empty.
  - Pop the head entry on rsp handshake.
- Response arriving with FIFO empty is a protocol violation: not accepted (rsp_ready=0), no output beat.
- Full FIFO: blocks new commands even if a pop occurs the same cycle. Full is a registered state; there is no bypass.
- Simultaneous push and pop (not full): count unchanged, both pointers advance. Pointers wrap modulo OTF_DEPTH.
- Load data formatting, using the head entry:
  - shifted = lsu_icb_rsp_rdata >> (addr[1:0]*8).
  - Byte: bits[7:0], extended from bit 7 unless usign.
  - Half: bits[15:0], extended from bit 15 unless usign.
  - Word: unshifted rdata.
  - Size 11: treated as word.
- agu_icb_rsp_rdata = lsu_o_wbck_wdat = formatted data for loads, 0 for stores.
- Commit flags: lsu_o_cmt_ld = head.read. lsu_o_cmt_err = lsu_icb_rsp_err, gated by lsu_o_valid.
- Responses return in order, one per command.
- Reset mid-operation discards all outstanding entries; any later stray responses fall under the empty rule.

Decomposition:
- Shared constants in defines.v:
  - `LSU_OTF_W (6).
  - Entry field indices `LSU_OTF_READ, `LSU_OTF_SIZE, `LSU_OTF_USIGN, `LSU_OTF_OFST.
  - Size encodings shared with the AGU decode info.
- One sub-module, exu_lsu_otf_fifo:
  - Generic synchronous FIFO with parameters DEPTH and WIDTH.
  - Ports: clk, rst_n, push, pop, din, dout (head), full, empty.
  - Fall-through head, registered count.

Test Plan:
- LB at addr 0x1003, usign=0, rsp_rdata=0x80FFFFFF -> wbck_wdat 0xFFFFFF80, cmt_ld=1; with usign=1 -> 0x00000080.
- LH at 0x2002, rdata=0x7FFF1234 -> 0x00007FFF; same with rdata=0x8001xxxx, signed -> 0xFFFF8001.
- SW at 0x3000, wdata 0xDEADBEEF, wmask 4'hF -> bus sees identical cmd; response yields lsu_o_valid=1, cmt_ld=0, wdat=0.
- OTF_DEPTH=2, issue 3 back-to-back loads with no response -> third command sees agu_icb_cmd_ready=0 and lsu_active=1. Respond once -> third accepted the next cycle. Responses return data in issue order.
- Hold lsu_o_ready=0 with a response pending -> rsp_ready=0 and FIFO count held. Release -> single pop.
- Response with rsp_err=1 -> cmt_err=1 on that beat only. Stray rsp_valid with FIFO empty -> rsp_ready=0, lsu_o_valid=0. Assert rst_n low with 2 outstanding -> lsu_active=0 immediately.
